// File: rtl/vlc_tx_pkg.sv
// Shared definitions for the VLC transmit path: FSM encoding, link timing and frame layout.
package vlc_tx_pkg;

  // Encoder half-bit length in clk16x cycles
  localparam int unsigned HALF_BIT_LEN = 40;

  // Position of the LEN byte within a transmitted frame; payload follows, checksum last
  localparam int unsigned LEN_IDX = 0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StDrain,
    StGap,
    StFlush
  } tx_state_e;

endpackage

// File: rtl/vlc_rr_arb2.sv
// Two-way round-robin arbiter. The requester that did not win last time has priority;
// after reset requester 0 has priority.
module vlc_rr_arb2 (
  input  logic       clk16x,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_q, prio_d;

  // Grant the priority requester if it asks, else the other one
  always_comb begin
    grant = 2'b00;
    if (req[prio_q]) begin
      grant[prio_q] = 1'b1;
    end else if (req[~prio_q]) begin
      grant[~prio_q] = 1'b1;
    end
  end

  // On advance, hand priority to whichever requester did not win
  always_comb begin
    prio_d = prio_q;
    if (advance && (grant != 2'b00)) begin
      prio_d = grant[0];
    end
  end

  // Priority pointer register
  always_ff @(posedge clk16x or negedge resetn) begin
    if (!resetn) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/vlc_tx_frame_ctrl.sv
// Frame scheduler in front of the Manchester encoder: picks a requester round-robin, buffers
// one payload, then feeds LEN, payload and optional XOR checksum through the encoder handshake,
// followed by a forced idle gap on the link.
module vlc_tx_frame_ctrl
  import vlc_tx_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 32,
  parameter bit          CHK_EN     = 1'b1,
  parameter int unsigned GAP_CYCLES = 4 * HALF_BIT_LEN
) (
  input  logic       clk16x,
  input  logic       resetn,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       enc_encode,
  output logic [7:0] enc_data,
  input  logic       enc_ready,
  input  logic       enc_encoding,
  output logic       busy,
  output logic [1:0] grant,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned CntW  = $clog2(MAX_LEN + 1);
  localparam int unsigned IdxW  = CntW + 1;  // holds T = cnt + 2 at most
  localparam int unsigned AddrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);

  tx_state_e        state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       chk_q, chk_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             seen_q, seen_d;
  logic             enc_encode_q, enc_encode_d;
  logic [7:0]       enc_data_q, enc_data_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;

  logic [7:0]       buf_q [MAX_LEN];
  logic             buf_we;

  logic [1:0]       arb_req, arb_grant;
  logic             arb_adv;
  logic             sel_valid, sel_last, accepting;
  logic [7:0]       sel_data, seq_byte;
  logic [IdxW-1:0]  tot;

  // Outside IDLE the arbiter sees only the current owner, so advance rotates away from it
  assign arb_req = (state_q == StIdle) ? {s1_valid, s0_valid} : grant_q;

  vlc_rr_arb2 u_arb (
    .clk16x  (clk16x),
    .resetn  (resetn),
    .req     (arb_req),
    .advance (arb_adv),
    .grant   (arb_grant)
  );

  // Route the granted requester's stream and compute the next frame byte for pulse idx_q
  always_comb begin
    sel_valid = grant_q[1] ? s1_valid : (grant_q[0] & s0_valid);
    sel_data  = grant_q[1] ? s1_data : s0_data;
    sel_last  = grant_q[1] ? s1_last : s0_last;
    accepting = (state_q == StLoad) || (state_q == StFlush);
    tot       = IdxW'(cnt_q) + IdxW'(1) + IdxW'(CHK_EN);
    if (idx_q == IdxW'(LEN_IDX)) begin
      seq_byte = 8'(cnt_q);
    end else if (idx_q <= IdxW'(cnt_q)) begin
      seq_byte = buf_q[AddrW'(idx_q - IdxW'(1))];
    end else begin
      seq_byte = chk_q ^ 8'(cnt_q);
    end
  end

  // Frame FSM next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    chk_d        = chk_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    seen_d       = seen_q;
    enc_encode_d = enc_encode_q;
    enc_data_d   = enc_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    buf_we       = 1'b0;
    arb_adv      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_grant != 2'b00) begin
          grant_d = arb_grant;
          cnt_d   = '0;
          chk_d   = 8'h00;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (sel_valid) begin
          if (cnt_q == CntW'(MAX_LEN)) begin
            // Overlength: this byte is already one too many
            if (sel_last) begin
              frame_err_d = 1'b1;
              grant_d     = 2'b00;
              state_d     = StIdle;
            end else begin
              state_d = StFlush;
            end
          end else begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + CntW'(1);
            chk_d  = chk_q ^ sel_data;
            if (sel_last) begin
              enc_encode_d = 1'b1;
              enc_data_d   = 8'(cnt_d);
              idx_d        = '0;
              seen_d       = 1'b0;
              state_d      = StSend;
            end
          end
        end
      end
      StFlush: begin
        if (sel_valid && sel_last) begin
          frame_err_d = 1'b1;
          grant_d     = 2'b00;
          state_d     = StIdle;
        end
      end
      StSend: begin
        if (enc_encoding) begin
          seen_d = 1'b1;
        end
        if (enc_ready) begin
          if (idx_q == tot) begin
            // Encoder asks for a byte past the end: drop encode while the last one is in flight
            enc_encode_d = 1'b0;
            state_d      = StDrain;
          end else begin
            enc_data_d = seq_byte;
            idx_d      = idx_q + IdxW'(1);
          end
        end
      end
      StDrain: begin
        if (enc_encoding) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          frame_done_d = 1'b1;
          gap_d        = '0;
          state_d      = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          arb_adv = 1'b1;
          grant_d = 2'b00;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk16x or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      grant_q      <= 2'b00;
      cnt_q        <= '0;
      chk_q        <= 8'h00;
      idx_q        <= '0;
      gap_q        <= '0;
      seen_q       <= 1'b0;
      enc_encode_q <= 1'b0;
      enc_data_q   <= 8'h00;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      chk_q        <= chk_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      seen_q       <= seen_d;
      enc_encode_q <= enc_encode_d;
      enc_data_q   <= enc_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Payload buffer write port, no reset needed
  always_ff @(posedge clk16x) begin
    if (buf_we) begin
      buf_q[AddrW'(cnt_q)] <= sel_data;
    end
  end

  assign s0_ready   = accepting & grant_q[0];
  assign s1_ready   = accepting & grant_q[1];
  assign busy       = (state_q != StIdle);
  assign grant      = grant_q;
  assign enc_encode = enc_encode_q;
  assign enc_data   = enc_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_vlc_tx_frame_ctrl.sv
// Bench for vlc_tx_frame_ctrl: instance 0 with checksum, instance 1 without, both MAX_LEN=4.
// A behavioural encoder model per instance captures transmitted bytes against a scoreboard.
module tb_vlc_tx_frame_ctrl;

  localparam int unsigned MaxLen   = 4;
  localparam int unsigned GapCyc   = 160;
  localparam int          PulseGap = 8;

  typedef logic [7:0] bytes_t [8];

  logic clk16x = 1'b0;
  logic resetn = 1'b0;
  always #5 clk16x = ~clk16x;

  logic       sv [2][2];
  logic [7:0] sd [2][2];
  logic       sl [2][2];
  logic       enc_ready_r [2];
  logic       enc_enc_r [2];

  wire [1:0][1:0] sr;
  wire [1:0]      enc_encode;
  wire [1:0][7:0] enc_data;
  wire [1:0]      busy;
  wire [1:0][1:0] grant;
  wire [1:0]      frame_done;
  wire [1:0]      frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard: expected byte stream and per-frame byte counts, per instance
  logic [7:0] exp_byte [2][512];
  int exp_wr [2];
  int rx_idx [2];
  int exp_tot [2][64];
  int exp_fw [2];
  int fr_rd [2];
  int exp_done [2];
  int exp_err [2];
  int n_done [2];
  int n_err [2];
  int last_done_cyc [2];
  bit have_done [2];
  int acc_cyc [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vlc_tx_frame_ctrl #(
      .MAX_LEN    (MaxLen),
      .CHK_EN     (g == 0),
      .GAP_CYCLES (GapCyc)
    ) u_dut (
      .clk16x       (clk16x),
      .resetn       (resetn),
      .s0_valid     (sv[g][0]),
      .s0_data      (sd[g][0]),
      .s0_last      (sl[g][0]),
      .s0_ready     (sr[g][0]),
      .s1_valid     (sv[g][1]),
      .s1_data      (sd[g][1]),
      .s1_last      (sl[g][1]),
      .s1_ready     (sr[g][1]),
      .enc_encode   (enc_encode[g]),
      .enc_data     (enc_data[g]),
      .enc_ready    (enc_ready_r[g]),
      .enc_encoding (enc_enc_r[g]),
      .busy         (busy[g]),
      .grant        (grant[g]),
      .frame_done   (frame_done[g]),
      .frame_err    (frame_err[g])
    );

    // Encoder model: ready pulse k asks for byte k; a pulse answered with encode low ends the frame
    initial begin : enc_model
      int  nbytes;
      bit  aborted;
      enc_ready_r[g] = 1'b0;
      enc_enc_r[g]   = 1'b0;
      forever begin
        @(posedge clk16x);
        #1;
        if (enc_encode[g] && resetn) begin
          if (have_done[g]) check("gap", 32'((cyc - last_done_cyc[g]) >= int'(GapCyc)), 1);
          nbytes  = 0;
          aborted = 1'b0;
          repeat (2) @(posedge clk16x);
          #1 enc_enc_r[g] = 1'b1;
          forever begin
            repeat (PulseGap) @(posedge clk16x);
            #1 enc_ready_r[g] = 1'b1;
            @(posedge clk16x);
            #1 enc_ready_r[g] = 1'b0;
            if (!resetn) aborted = 1'b1;
            if (!enc_encode[g] || !resetn) break;
            if (rx_idx[g] < exp_wr[g]) check("enc_byte", enc_data[g], exp_byte[g][rx_idx[g]]);
            else check("extra_byte", rx_idx[g], exp_wr[g]);
            rx_idx[g]++;
            nbytes++;
          end
          repeat (10) @(posedge clk16x);
          #1 enc_enc_r[g] = 1'b0;
          if (!aborted) begin
            if (fr_rd[g] < exp_fw[g]) check("frame_len", nbytes, exp_tot[g][fr_rd[g]]);
            else check("extra_frame", fr_rd[g], exp_fw[g]);
            fr_rd[g]++;
          end
        end
      end
    end
  end

  always @(posedge clk16x) cyc <= cyc + 1;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk16x) begin
    for (int u = 0; u < 2; u++) begin
      if (frame_done[u]) begin
        n_done[u]        <= n_done[u] + 1;
        last_done_cyc[u] <= cyc;
        have_done[u]     <= 1'b1;
      end
      if (frame_err[u]) n_err[u] <= n_err[u] + 1;
    end
  end

  // Push one frame from requester r of instance u; stall_at>=0 drops valid 10 cycles before that byte
  task automatic send_frame(input int u, input int r, input int n, input bytes_t pay,
                            input int stall_at);
    logic [7:0] x;
    bit         over;
    int         t;
    over = (n > int'(MaxLen));
    x    = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        sv[u][r] = 1'b0;
        repeat (10) @(posedge clk16x);
        #1;
      end
      sv[u][r] = 1'b1;
      sd[u][r] = pay[i];
      sl[u][r] = (i == n - 1);
      t = 0;
      while (!sr[u][r] && t < 3000) begin
        @(posedge clk16x);
        #1;
        t++;
      end
      if (t >= 3000) begin
        check("ready_timeout", 0, 1);
        sv[u][r] = 1'b0;
        return;
      end
      @(posedge clk16x);
      #1;
      if (i == 0) check("grant", grant[u], 32'(2'b01 << r));
      if (i < int'(MaxLen)) x ^= pay[i];
    end
    sv[u][r]   = 1'b0;
    sl[u][r]   = 1'b0;
    acc_cyc[r] = cyc;
    check("frame_err", frame_err[u], over);
    if (over) begin
      exp_err[u]++;
    end else begin
      exp_byte[u][exp_wr[u]] = 8'(n);
      exp_wr[u]++;
      for (int i = 0; i < n; i++) begin
        exp_byte[u][exp_wr[u]] = pay[i];
        exp_wr[u]++;
      end
      if (u == 0) begin
        exp_byte[u][exp_wr[u]] = x ^ 8'(n);
        exp_wr[u]++;
      end
      exp_tot[u][exp_fw[u]] = n + 1 + ((u == 0) ? 1 : 0);
      exp_fw[u]++;
      exp_done[u]++;
    end
  endtask

  task automatic wait_idle(input int u);
    int t;
    t = 0;
    do begin
      @(posedge clk16x);
      #1;
      t++;
    end while (busy[u] && t < 5000);
    check("idle", busy[u], 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_ready"}, sr, 0);
    check({tag, "_encode"}, enc_encode, 0);
    check({tag, "_data"}, enc_data, 0);
    check({tag, "_done_err"}, {frame_done, frame_err}, 0);
  endtask

  initial begin
    bytes_t pa, pb;
    int n, r, st;
    for (int u = 0; u < 2; u++) begin
      for (int q = 0; q < 2; q++) begin
        sv[u][q] = 1'b0;
        sd[u][q] = 8'h00;
        sl[u][q] = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      pa[i] = 8'h00;
      pb[i] = 8'h00;
    end
    repeat (3) @(posedge clk16x);
    #1;
    check_quiet("reset");
    resetn = 1'b1;
    @(posedge clk16x);
    #1;

    // Both requesters at once after reset: 0 wins first, 1 follows after the gap
    pa[0] = 8'h5A;
    pb[0] = 8'hC3;
    fork
      send_frame(0, 0, 1, pa, -1);
      send_frame(0, 1, 1, pb, -1);
    join
    check("rr_order", 32'(acc_cyc[0] < acc_cyc[1]), 1);
    wait_idle(0);

    // Three-byte frame: LEN, A5, 3C, FF, checksum
    pa[0] = 8'hA5;
    pa[1] = 8'h3C;
    pa[2] = 8'hFF;
    send_frame(0, 0, 3, pa, -1);
    wait_idle(0);

    // LEN == MAX_LEN with valid dropping mid-load
    for (int i = 0; i < 4; i++) pa[i] = 8'(8'h10 * i + 8'h07);
    send_frame(0, 0, 4, pa, 2);
    wait_idle(0);

    // Overlength: six bytes, error on the sixth, nothing sent
    for (int i = 0; i < 6; i++) pa[i] = 8'($urandom);
    send_frame(0, 1, 6, pa, -1);
    wait_idle(0);
    check("no_encode_after_err", enc_encode[0], 0);

    // No-checksum instance, single zero byte
    pa[0] = 8'h00;
    send_frame(1, 0, 1, pa, -1);
    wait_idle(1);

    // Reset while the second payload byte is on offer
    sv[0][0] = 1'b1;
    sd[0][0] = 8'h11;
    sl[0][0] = 1'b0;
    repeat (2) @(posedge clk16x);
    #1;
    sd[0][0] = 8'h22;
    #3 resetn = 1'b0;
    #1 check("midrst_busy", busy[0], 0);
    check("midrst_ready", sr[0], 0);
    @(posedge clk16x);
    #1;
    check_quiet("midrst");
    sv[0][0] = 1'b0;
    repeat (2) @(posedge clk16x);
    #1 resetn = 1'b1;
    @(posedge clk16x);
    #1;

    // Pointer back at requester 0 after reset
    pa[0] = 8'h01;
    pb[0] = 8'hFE;
    fork
      send_frame(0, 0, 1, pa, -1);
      send_frame(0, 1, 1, pb, -1);
    join
    check("rr_order_after_reset", 32'(acc_cyc[0] < acc_cyc[1]), 1);
    wait_idle(0);

    // Randomized frames, lengths 1..MAX_LEN+2
    for (int f = 0; f < 18; f++) begin
      int u;
      u = (f % 3 == 2) ? 1 : 0;
      n = int'($urandom_range(MaxLen + 2, 1));
      r = int'($urandom_range(1, 0));
      st = ($urandom_range(3, 0) == 0 && n > 1) ? int'($urandom_range(n - 1, 1)) : -1;
      for (int i = 0; i < 8; i++) pa[i] = 8'($urandom);
      send_frame(u, r, n, pa, st);
      wait_idle(u);
    end

    repeat (20) @(posedge clk16x);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("done_count", n_done[u], exp_done[u]);
      check("err_count", n_err[u], exp_err[u]);
      check("bytes_seen", rx_idx[u], exp_wr[u]);
      check("frames_seen", fr_rd[u], exp_fw[u]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
